dcache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller directly downstream of the MEM stage.
- Address split is fixed: index = addr[3:2], tag = addr[31:4].
- Serves word loads/stores from the MEM stage and stalls the pipeline on misses and stores.
- Talks to main memory over a req/ack handshake with variable latency.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_array.sv | 50 +++++
 rtl/dcache_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 cache controllers: state encoding, default
// geometry and address slicing helpers.
package dcache_pkg;

  localparam int INDEX_W_DEF = 2;
  localparam int TAG_W_DEF   = 28;
  localparam int LINES_DEF   = 1 << INDEX_W_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [INDEX_W_DEF-1:0] addr_index(input logic [31:0] addr);
    return addr[INDEX_W_DEF+1:2];
  endfunction

  function automatic logic [TAG_W_DEF-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:INDEX_W_DEF+2];
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for a direct-mapped cache: combinational read port,
// one synchronous write port, valid bits cleared asynchronously.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES   = LINES_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INDEX_W-1:0] i_rd_idx,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [31:0]        o_rd_data,
  input  logic               i_fill_we,
  input  logic               i_data_we,
  input  logic [INDEX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [31:0]        i_wr_data
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // Valid bits: cleared by reset, set by a line fill.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
    end else if (i_fill_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset; an invalid line is never read as a hit.
  always_ff @(posedge i_clk) begin
    if (i_fill_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end else if (i_data_we) begin
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller sitting
// behind the MEM stage; stalls the pipeline on load misses and on every store.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES   = LINES_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  state_t r_state;
  state_t w_next_state;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [31:0]        w_word_addr;
  logic               w_rd_req;
  logic               w_wr_req;
  logic               w_arr_valid;
  logic [TAG_W-1:0]   w_arr_tag;
  logic [31:0]        w_arr_data;
  logic               w_hit;
  logic               w_fill;
  logic               w_store_hit;
  logic [31:0]        r_fill_data;
  logic [1:0]         w_unused_addr_lsb;

  assign w_idx             = addr_index(cpu_addr);
  assign w_tag             = addr_tag(cpu_addr);
  assign w_word_addr       = word_addr(cpu_addr);
  assign w_unused_addr_lsb = cpu_addr[1:0];

  // A store takes priority; a simultaneous load request is dropped.
  assign w_wr_req    = cpu_write;
  assign w_rd_req    = cpu_read & ~cpu_write;
  assign w_hit       = w_arr_valid && (w_arr_tag == w_tag);
  assign w_fill      = (r_state == RD_WAIT) && mem_ack;
  assign w_store_hit = (r_state == IDLE) && w_wr_req && w_hit;

  dcache_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_arr_valid),
    .o_rd_tag   (w_arr_tag),
    .o_rd_data  (w_arr_data),
    .i_fill_we  (w_fill),
    .i_data_we  (w_store_hit),
    .i_wr_idx   (w_idx),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_fill ? mem_rdata : cpu_wdata)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus the combinational stall and load-data outputs.
  always_comb begin
    w_next_state = r_state;
    cpu_stall    = 1'b0;
    cpu_rdata    = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_wr_req) begin
          cpu_stall    = 1'b1;
          w_next_state = WR_WAIT;
        end else if (w_rd_req) begin
          if (w_hit) begin
            cpu_rdata = w_arr_data;
          end else begin
            cpu_stall    = 1'b1;
            w_next_state = RD_WAIT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      RD_WAIT: begin
        cpu_stall    = 1'b1;
        w_next_state = mem_ack ? DONE : RD_WAIT;
      end
      WR_WAIT: begin
        cpu_stall    = 1'b1;
        w_next_state = mem_ack ? DONE : WR_WAIT;
      end
      DONE: begin
        // The replayed access completes here and is deliberately not counted.
        cpu_rdata    = r_fill_data;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Memory request registers, fill-data capture and load hit/miss counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      r_fill_data <= 32'd0;
      hit_count   <= 32'd0;
      miss_count  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= w_word_addr;
            mem_wdata <= cpu_wdata;
          end else if (w_rd_req) begin
            if (w_hit) begin
              hit_count <= hit_count + 32'd1;
            end else begin
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= w_word_addr;
              miss_count <= miss_count + 32'd1;
            end
          end
        end
        RD_WAIT: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            r_fill_data <= mem_rdata;
          end
        end
        WR_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          mem_req <= mem_req;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a driver issues accesses and predicts the
// outcome from a line-ownership model, a responder plays memory, a monitor checks.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count, miss_count;

  dcache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    bit          hit;
    logic [31:0] rdata;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t memq[$];
  int    n_q[$];

  logic [31:0] mem_model [logic [29:0]];
  bit          line_val [4];
  logic [29:0] line_wa  [4];
  logic [31:0] m_hits, m_misses;

  int n_cmp  = 0;
  int n_fail = 0;
  int forced_n = 0;
  bit late_ack_req = 1'b0;

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem_model.exists(wa)) return mem_model[wa];
    return {wa[15:0], ~wa[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) line_val[i] = 1'b0;
    m_hits   = 32'd0;
    m_misses = 32'd0;
    exp_q.delete();
    memq.delete();
    n_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [29:0] wa;
    int          idx;
    bit          hit;
    bit          accepted;
    int          cyc;
    exp_t        e;
    wa  = addr[31:2];
    idx = int'(wa[1:0]);
    hit = line_val[idx] && (line_wa[idx] == wa);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    if (wr) begin
      mem_model[wa] = wd;
      memq.push_back('{we: 1'b1, addr: {wa, 2'b00}, wdata: wd});
      e = '{is_read: 1'b0, hit: 1'b0, rdata: 32'd0, hits: m_hits, misses: m_misses};
    end else if (hit) begin
      e = '{is_read: 1'b1, hit: 1'b1, rdata: mem_rd(wa), hits: m_hits, misses: m_misses};
      m_hits = m_hits + 32'd1;
    end else begin
      m_misses = m_misses + 32'd1;
      line_val[idx] = 1'b1;
      line_wa[idx]  = wa;
      memq.push_back('{we: 1'b0, addr: {wa, 2'b00}, wdata: 32'd0});
      e = '{is_read: 1'b1, hit: 1'b0, rdata: mem_rd(wa), hits: m_hits, misses: m_misses};
    end
    exp_q.push_back(e);
    accepted = 1'b0;
    cyc = 0;
    while (!accepted && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!cpu_stall) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    if (!accepted) begin
      n_cmp++;
      n_fail++;
      $display("FAIL access_timeout: stall still high after %0d cycles, addr %h", cyc, addr);
      finish_run();
    end
  endtask

  // Monitor: every cycle a request is presented without stall, one access retires.
  initial begin
    int   scnt;
    int   n;
    exp_t e;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        scnt = 0;
      end else if (cpu_read || cpu_write) begin
        if (cpu_stall) begin
          scnt++;
        end else begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e.is_read) check("cpu_rdata", cpu_rdata, e.rdata);
            check("hit_count", hit_count, e.hits);
            check("miss_count", miss_count, e.misses);
            if (e.hit) begin
              check("hit_stall_cycles", 32'(scnt), 32'd0);
            end else if (n_q.size() == 0) begin
              check("missing_mem_ack", 32'(scnt), 32'd0);
            end else begin
              n = n_q.pop_front();
              check("stall_cycles", 32'(scnt), 32'(1 + n));
            end
          end
          scnt = 0;
        end
      end
    end
  end

  // Memory responder: checks each request, acks after N cycles of mem_req.
  initial begin
    int    left;
    int    n;
    mreq_t m;
    left = 0;
    n = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset) begin
        left = 0;
      end else if (late_ack_req) begin
        mem_ack      = 1'b1;
        mem_rdata    = 32'hBAD0_BAD0;
        late_ack_req = 1'b0;
      end else if (mem_req) begin
        if (left == 0) begin
          n = (forced_n != 0) ? forced_n : int'($urandom_range(1, 4));
          left = n;
          if (memq.size() == 0) begin
            check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
          end else begin
            m = memq.pop_front();
            check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
            check("mem_addr", mem_addr, m.addr);
            if (m.we) check("mem_wdata", mem_wdata, m.wdata);
          end
        end
        left--;
        if (left == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_we ? $urandom : mem_rd(mem_addr[31:2]);
          n_q.push_back(n);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: run exceeded time limit");
    finish_run();
  end

  initial begin
    int          cyc;
    logic [27:0] tsel;
    logic [1:0]  idx, lsb;
    int          op;
    reset     = 1'b1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    mem_model[30'h4] = 32'hDEAD_BEEF;
    forced_n = 3;
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    forced_n = 1;
    access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    forced_n = 2;
    access(1'b1, 1'b0, 32'h0000_0050, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    access(1'b0, 1'b1, 32'h0000_0024, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 32'h0000_0024, 32'd0);
    access(1'b1, 1'b1, 32'h0000_0038, 32'h0BAD_CAFE);
    access(1'b1, 1'b0, 32'h0000_0038, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0038, 32'd0);

    // Reset while a read miss is waiting for memory.
    forced_n = 4;
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_0014;
    memq.push_back('{we: 1'b0, addr: 32'h0000_0014, wdata: 32'd0});
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_req && cyc < 10);
    check("reset_test_req_seen", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_drop_mem_req", {31'd0, mem_req}, 32'd0);
    cpu_read = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    late_ack_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("late_ack_stall", {31'd0, cpu_stall}, 32'd0);
    check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    check("post_reset_hits", hit_count, 32'd0);
    check("post_reset_misses", miss_count, 32'd0);
    forced_n = 0;
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0);

    for (int i = 0; i < 300; i++) begin
      tsel = ($urandom_range(0, 7) == 0) ? 28'($urandom) : 28'($urandom_range(0, 3));
      idx  = 2'($urandom_range(0, 3));
      lsb  = 2'($urandom_range(0, 3));
      op   = int'($urandom_range(0, 19));
      if (op < 10)      access(1'b1, 1'b0, {tsel, idx, lsb}, 32'd0);
      else if (op < 17) access(1'b0, 1'b1, {tsel, idx, lsb}, $urandom);
      else              access(1'b1, 1'b1, {tsel, idx, lsb}, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check("final_hits", hit_count, m_hits);
    check("final_misses", miss_count, m_misses);
    check("scoreboard_drained", 32'(exp_q.size() + memq.size() + n_q.size()), 32'd0);
    finish_run();
  end

endmodule
